// File: rtl/fizzbuzz_pkg.sv
// Shared types and default constants for the FizzBuzz run controller and its checker.
package fizzbuzz_pkg;

   localparam int FB_MAX_CYCLES = 30;
   localparam int FB_RST_CYCLES = 2;
   localparam int FB_MODEL_LAT  = 2;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      WARM,
      RUN,
      DONE
   } fb_state_t;

   typedef enum logic [1:0] {
      NONE,
      FIZZ,
      BUZZ,
      FIZZBUZZ
   } fb_class_t;

   // Collapse the model's three flags into one class; fizzbuzz wins over fizz over buzz.
   function automatic fb_class_t fb_classify(input logic fz, input logic bz, input logic fb);
      if (fb)      return FIZZBUZZ;
      else if (fz) return FIZZ;
      else if (bz) return BUZZ;
      return NONE;
   endfunction

   // Class the reference expects for an index, given its residues mod 3 and mod 5.
   function automatic fb_class_t fb_expect(input logic [1:0] m3, input logic [2:0] m5);
      if (m3 == 2'd0 && m5 == 3'd0) return FIZZBUZZ;
      else if (m3 == 2'd0)          return FIZZ;
      else if (m5 == 3'd0)          return BUZZ;
      return NONE;
   endfunction

endpackage

// File: rtl/fizzbuzz_seq_ctrl_if.sv
// Host/model-facing signal bundle of the run controller; slave = controller, master = host + model.
interface fizzbuzz_seq_ctrl_if #(
   parameter int LEN_W = $clog2(fizzbuzz_pkg::FB_MAX_CYCLES + 1)
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             abort;
   logic             fizz;
   logic             buzz;
   logic             fizzbuzz;
   logic             model_resetn;
   logic             busy;
   logic             out_valid;
   logic [LEN_W-1:0] out_idx;
   logic             done;
   logic             aborted;
   logic [LEN_W-1:0] fizz_cnt;
   logic [LEN_W-1:0] buzz_cnt;
   logic [LEN_W-1:0] fb_cnt;
   logic             err;
   logic [LEN_W-1:0] err_idx;

   modport master (
      output start, len, abort, fizz, buzz, fizzbuzz,
      input  model_resetn, busy, out_valid, out_idx, done, aborted,
             fizz_cnt, buzz_cnt, fb_cnt, err, err_idx
   );

   modport slave (
      input  start, len, abort, fizz, buzz, fizzbuzz,
      output model_resetn, busy, out_valid, out_idx, done, aborted,
             fizz_cnt, buzz_cnt, fb_cnt, err, err_idx
   );
endinterface

// File: rtl/fizzbuzz_ref_chk.sv
// Reference checker: tracks out_idx mod 3 / mod 5 and latches the first index whose model flags disagree.
module fizzbuzz_ref_chk
   import fizzbuzz_pkg::*;
#(
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             resetn_tb,
   input  logic             clr,
   input  logic             out_valid,
   input  logic [LEN_W-1:0] out_idx,
   input  logic             fizz,
   input  logic             buzz,
   input  logic             fizzbuzz,
   output logic             err,
   output logic [LEN_W-1:0] err_idx
);

   logic [1:0] m3;
   logic [2:0] m5;
   fb_class_t  exp_cls;
   logic       miss;

   // Outside a valid burst the residues park at index 1's values, so every burst starts aligned.
   always_ff @(posedge clk or negedge resetn_tb) begin
      if (!resetn_tb) begin
         m3 <= 2'd1;
         m5 <= 3'd1;
      end else if (out_valid) begin
         m3 <= (m3 == 2'd2) ? 2'd0 : m3 + 2'd1;
         m5 <= (m5 == 3'd4) ? 3'd0 : m5 + 3'd1;
      end else begin
         m3 <= 2'd1;
         m5 <= 3'd1;
      end
   end

   assign exp_cls = fb_expect(m3, m5);
   assign miss    = out_valid &&
                    ({fizzbuzz, fizz, buzz} !=
                     {exp_cls == FIZZBUZZ, exp_cls == FIZZ, exp_cls == BUZZ});

   always_ff @(posedge clk or negedge resetn_tb) begin
      if (!resetn_tb) begin
         err     <= 1'b0;
         err_idx <= '0;
      end else if (clr) begin
         err     <= 1'b0;
         err_idx <= '0;
      end else if (miss && !err) begin
         err     <= 1'b1;
         err_idx <= out_idx;
      end
   end

endmodule

// File: rtl/fizzbuzz_seq_ctrl.sv
// Run controller for the FizzBuzz model: drives model reset, qualifies outputs, keeps tallies.
// Define FIZZBUZZ_CHECK_EN to compile in the reference checker (err/err_idx otherwise tied to 0).
module fizzbuzz_seq_ctrl
   import fizzbuzz_pkg::*;
#(
   parameter int MAX_CYCLES = FB_MAX_CYCLES,
   parameter int RST_CYCLES = FB_RST_CYCLES,
   parameter int MODEL_LAT  = FB_MODEL_LAT,
   parameter int LEN_W      = $clog2(MAX_CYCLES + 1)
) (
   input logic                clk,
   input logic                resetn_tb,
   fizzbuzz_seq_ctrl_if.slave bus
);

   localparam logic [LEN_W-1:0] RST_LD  = LEN_W'(RST_CYCLES - 1);
   localparam logic [LEN_W-1:0] LAT_LD  = LEN_W'(MODEL_LAT - 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CYCLES);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   fb_state_t        state, state_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic [LEN_W-1:0] eff_len, eff_len_nxt;
   logic             go, kill;

   logic             mres_q, busy_q, vld_q, done_q, abd_q;
   logic [LEN_W-1:0] idx_q;
   logic             mres_nxt, busy_nxt, vld_nxt, done_nxt, abd_nxt;
   logic [LEN_W-1:0] idx_nxt;
   logic [LEN_W-1:0] fz_q, bz_q, fb_q;
   logic             err_q;
   logic [LEN_W-1:0] err_idx_q;

   assign go   = (state == IDLE) && bus.start;
   assign kill = bus.abort && (state inside {RST, WARM, RUN});

   always_ff @(posedge clk or negedge resetn_tb) begin
      if (!resetn_tb) begin
         state   <= IDLE;
         cnt     <= '0;
         eff_len <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         eff_len <= eff_len_nxt;
      end
   end

   // One down-counter times RST, WARM and RUN; it is reloaded on each phase change.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      eff_len_nxt = eff_len;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt   = RST;
                  cnt_nxt     = RST_LD;
                  eff_len_nxt = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
               end
            end
         end
         RST: begin
            if (bus.abort) state_nxt = DONE;
            else if (cnt == '0) begin
               state_nxt = WARM;
               cnt_nxt   = LAT_LD;
            end else cnt_nxt = cnt - ONE;
         end
         WARM: begin
            if (bus.abort) state_nxt = DONE;
            else if (cnt == '0) begin
               state_nxt = RUN;
               cnt_nxt   = eff_len - ONE;
            end else cnt_nxt = cnt - ONE;
         end
         RUN: begin
            if (bus.abort || cnt == '0) state_nxt = DONE;
            else cnt_nxt = cnt - ONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with the state.
   always_comb begin
      mres_nxt = (state_nxt == WARM) || (state_nxt == RUN);
      busy_nxt = (state_nxt != IDLE);
      vld_nxt  = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
      abd_nxt  = kill;
      idx_nxt  = '0;
      if (state_nxt == RUN) idx_nxt = (state == RUN) ? idx_q + ONE : ONE;
   end

   always_ff @(posedge clk or negedge resetn_tb) begin
      if (!resetn_tb) begin
         mres_q <= 1'b0;
         busy_q <= 1'b0;
         vld_q  <= 1'b0;
         idx_q  <= '0;
         done_q <= 1'b0;
         abd_q  <= 1'b0;
      end else begin
         mres_q <= mres_nxt;
         busy_q <= busy_nxt;
         vld_q  <= vld_nxt;
         idx_q  <= idx_nxt;
         done_q <= done_nxt;
         abd_q  <= abd_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn_tb) begin
      if (!resetn_tb) begin
         fz_q <= '0;
         bz_q <= '0;
         fb_q <= '0;
      end else if (go) begin
         fz_q <= '0;
         bz_q <= '0;
         fb_q <= '0;
      end else if (vld_q) begin
         unique case (fb_classify(bus.fizz, bus.buzz, bus.fizzbuzz))
            FIZZBUZZ: fb_q <= fb_q + ONE;
            FIZZ:     fz_q <= fz_q + ONE;
            BUZZ:     bz_q <= bz_q + ONE;
            default:  ;
         endcase
      end
   end

`ifdef FIZZBUZZ_CHECK_EN
   fizzbuzz_ref_chk #(
      .LEN_W(LEN_W)
   ) u_chk (
      .clk       (clk),
      .resetn_tb (resetn_tb),
      .clr       (go),
      .out_valid (vld_q),
      .out_idx   (idx_q),
      .fizz      (bus.fizz),
      .buzz      (bus.buzz),
      .fizzbuzz  (bus.fizzbuzz),
      .err       (err_q),
      .err_idx   (err_idx_q)
   );
`else
   assign err_q     = 1'b0;
   assign err_idx_q = '0;
`endif

   assign bus.model_resetn = mres_q;
   assign bus.busy         = busy_q;
   assign bus.out_valid    = vld_q;
   assign bus.out_idx      = idx_q;
   assign bus.done         = done_q;
   assign bus.aborted      = abd_q;
   assign bus.fizz_cnt     = fz_q;
   assign bus.buzz_cnt     = bz_q;
   assign bus.fb_cnt       = fb_q;
   assign bus.err          = err_q;
   assign bus.err_idx      = err_idx_q;

endmodule

// File: tb/tb_fizzbuzz_seq_ctrl.sv
// Self-checking bench for fizzbuzz_seq_ctrl: directed table, hand sequences and randomized runs.
module tb_fizzbuzz_seq_ctrl;
   import fizzbuzz_pkg::*;

   localparam int MAXC = 30;
   localparam int RSTC = 2;
   localparam int LAT  = 2;
   localparam int LW   = 6;
   localparam int PRE  = RSTC + LAT;

   logic clk = 1'b0;
   logic resetn_tb;
   logic force_b0;
   always #5 clk = ~clk;

   fizzbuzz_seq_ctrl_if #(.LEN_W(LW)) bus ();

   fizzbuzz_seq_ctrl #(
      .MAX_CYCLES(MAXC), .RST_CYCLES(RSTC), .MODEL_LAT(LAT), .LEN_W(LW)
   ) dut (
      .clk       (clk),
      .resetn_tb (resetn_tb),
      .bus       (bus)
   );

   // Behavioural model: index 1 appears LAT cycles after its reset releases.
   logic [7:0] mcnt;
   int         midx;
   always @(posedge clk or negedge bus.model_resetn)
      if (!bus.model_resetn) mcnt <= 8'd0;
      else if (mcnt != 8'hff) mcnt <= mcnt + 8'd1;
   always_comb midx = int'(mcnt) - LAT + 1;
   assign bus.fizzbuzz = (midx > 0) && (midx % 15 == 0);
   assign bus.fizz     = (midx > 0) && (midx % 3 == 0) && (midx % 5 != 0);
   assign bus.buzz     = !force_b0 && (midx > 0) && (midx % 5 == 0) && (midx % 3 != 0);

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.model_resetn, bus.busy, bus.out_valid, bus.out_idx, bus.done, bus.aborted,
                  bus.fizz_cnt, bus.buzz_cnt, bus.fb_cnt, bus.err, bus.err_idx});
   endfunction

   // Number of indices 1..n of a class: 0 fizz-only, 1 buzz-only, 2 fizzbuzz.
   function automatic int ref_cnt(input int n, input int cls);
      int c = 0;
      for (int i = 1; i <= n; i++) begin
         if (cls == 0 && i % 3 == 0 && i % 5 != 0) c++;
         if (cls == 1 && i % 5 == 0 && i % 3 != 0) c++;
         if (cls == 2 && i % 15 == 0) c++;
      end
      return c;
   endfunction

   typedef struct {
      int len;    // requested length
      int ab;     // cycle after start to raise abort; 0 = with start, -1 = never
      int done_k; // expected done cycle after start
      int abd;
      int ef, eb, efb;
      int nv;     // expected out_valid cycles
   } vec_t;

   vec_t vt[9];

   task automatic run_vec(input vec_t v, input string nm);
      int  dk, nv;
      bit  idx_ok, mres_any;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = LW'(v.len);
      bus.abort = (v.ab == 0);
      dk = 0; nv = 0; idx_ok = 1'b1; mres_any = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.abort = (k == v.ab);
         if (bus.model_resetn) mres_any = 1'b1;
         if (bus.out_valid) begin
            nv++;
            if (bus.out_idx != LW'(nv)) idx_ok = 1'b0;
            if (nv == 1 && k != PRE + 1) idx_ok = 1'b0;
         end
         if (bus.done) begin
            dk = k;
            break;
         end
      end
      bus.abort = 1'b0;
      chk({nm, "/done_cyc"}, 64'(dk), 64'(v.done_k));
      chk({nm, "/aborted"}, 64'(bus.aborted), 64'(v.abd));
      chk({nm, "/mres_at_done"}, 64'(bus.model_resetn), 64'(0));
      chk({nm, "/tally"}, 64'({bus.fizz_cnt, bus.buzz_cnt, bus.fb_cnt}),
          64'({LW'(v.ef), LW'(v.eb), LW'(v.efb)}));
      chk({nm, "/n_valid"}, 64'(nv), 64'(v.nv));
      chk({nm, "/idx_seq"}, 64'(idx_ok), 64'(1));
      chk({nm, "/mres_seen"}, 64'(mres_any), 64'(v.done_k > RSTC + 1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int dk, n_d, n_b;
      vt[0] = '{15, -1, 20, 0, 4, 2, 1, 15};
      vt[1] = '{40, -1, 35, 0, 8, 4, 2, 30};
      vt[2] = '{ 0, -1,  1, 0, 0, 0, 0,  0};
      vt[3] = '{15,  8,  9, 1, 1, 0, 0,  4};
      vt[4] = '{ 5,  0, 10, 0, 1, 1, 0,  5};
      vt[5] = '{10,  1,  2, 1, 0, 0, 0,  0};
      vt[6] = '{10,  3,  4, 1, 0, 0, 0,  0};
      vt[7] = '{ 1, -1,  6, 0, 0, 0, 0,  1};
      vt[8] = '{30, -1, 35, 0, 8, 4, 2, 30};

      resetn_tb = 1'b0;
      force_b0  = 1'b0;
      bus.start = 1'b0;
      bus.len   = '0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset/outs", outs(), 64'(0));
      resetn_tb = 1'b1;

      // abort while idle must not start anything
      @(negedge clk); bus.abort = 1'b1;
      @(negedge clk); bus.abort = 1'b0;
      chk("idle_abort/busy_done", 64'({bus.busy, bus.done}), 64'(0));

      foreach (vt[i]) begin
         run_vec(vt[i], $sformatf("vec%0d", i));
         chk($sformatf("vec%0d/err", i), 64'(bus.err), 64'(0));
      end

      // randomized back-to-back runs against the timeline model
      for (int r = 0; r < 40; r++) begin
         int L, eff, ab, nrun, rdk, comp;
         logic [3:0] ectl;
         L    = int'($urandom_range(0, 63));
         eff  = (L > MAXC) ? MAXC : L;
         ab   = (L != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, PRE + eff)) : -1;
         nrun = (ab < 0) ? eff : ((ab > PRE) ? ab - PRE : 0);
         rdk  = (L == 0) ? 1 : ((ab > 0) ? ab + 1 : PRE + eff + 1);
         @(negedge clk);
         bus.start = 1'b1;
         bus.len   = LW'(L);
         bus.abort = 1'b0;
         for (int k = 1; k <= rdk; k++) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            bus.len   = LW'($urandom);
            bus.abort = (k == ab);
            ectl = {1'b1, (L != 0) && k > RSTC && k < rdk, (L != 0) && k > PRE && k < rdk, k == rdk};
            chk("rnd/ctl", 64'({bus.busy, bus.model_resetn, bus.out_valid, bus.done}), 64'(ectl));
            if (ectl[1]) chk("rnd/idx", 64'(bus.out_idx), 64'(k - PRE));
            if (ectl[0]) chk("rnd/aborted", 64'(bus.aborted), 64'(ab > 0));
            comp = k - PRE - 1;
            if (comp < 0) comp = 0;
            if (comp > nrun) comp = nrun;
            chk("rnd/tally", 64'({bus.fizz_cnt, bus.buzz_cnt, bus.fb_cnt}),
                64'({LW'(ref_cnt(comp, 0)), LW'(ref_cnt(comp, 1)), LW'(ref_cnt(comp, 2))}));
            chk("rnd/err", 64'(bus.err), 64'(0));
         end
         bus.start = 1'b0;
         bus.abort = 1'b0;
      end

      // reset in the middle of RUN: everything clears and no done follows
      @(negedge clk); bus.start = 1'b1; bus.len = LW'(15);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("rst_mid/in_run", 64'(bus.out_valid), 64'(1));
      resetn_tb = 1'b0;
      #1;
      chk("rst_mid/outs", outs(), 64'(0));
      @(negedge clk); resetn_tb = 1'b1;
      n_d = 0; n_b = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) n_d++;
         if (bus.busy) n_b++;
      end
      chk("rst_mid/no_done", 64'(n_d), 64'(0));
      chk("rst_mid/idle", 64'(n_b), 64'(0));
      run_vec(vt[0], "rst_mid/rerun");

`ifdef FIZZBUZZ_CHECK_EN
      force_b0 = 1'b1;
      @(negedge clk); bus.start = 1'b1; bus.len = LW'(15);
      dk = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) begin
            dk = k;
            break;
         end
      end
      force_b0 = 1'b0;
      chk("chk/done_cyc", 64'(dk), 64'(20));
      chk("chk/err", 64'(bus.err), 64'(1));
      chk("chk/err_idx", 64'(bus.err_idx), 64'(5));
      @(negedge clk); bus.start = 1'b1; bus.len = LW'(3);
      @(negedge clk); bus.start = 1'b0;
      chk("chk/err_clr", 64'({bus.err, bus.err_idx}), 64'(0));
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      chk("chk/err_clean_run", 64'(bus.err), 64'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
